mips32_mem_arbiter: RTL

- Arbitrates one single-port unified memory between the mips32 pipeline's instruction-fetch (IF) and data (MEM-stage load/store) ports.
- Allows at most one memory transaction in flight.
- Gives data accesses priority over fetches, with an optional anti-starvation mechanism for fetches.
- Produces per-port grant, read-valid and stall signals that the pipeline uses to freeze its stages.

---
 rtl/mips32_mem_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mips32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips32_mem_arbiter
//
// Shares one single-port unified memory between the instruction-fetch port
// and the MEM-stage data port of the mips32 pipeline. At most one memory
// transaction is in flight. Data accesses win over fetches. Defining the
// macro MEM_ARB_FAIR_EN adds an anti-starvation counter that forces a fetch
// after FAIR_MAX contested data grants.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata fetch grant pulse, read-valid, read data
//   d_req/d_we/d_addr/d_wdata data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata   data grant pulse, load-valid, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory side
//   stall_if/stall_mem       per-port "transaction pending" stalls
//
// Parameters: AW, DW, MEM_LAT (1..7 read latency), FAIR_MAX (1..15).
// ---------------------------------------------------------------------------
module mips32_mem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 2,
    parameter int FAIR_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    if (MEM_LAT < 1 || MEM_LAT > 7 || FAIR_MAX < 1 || FAIR_MAX > 15) begin : g_bad_param
        $error("mips32_mem_arbiter: MEM_LAT must be 1..7 and FAIR_MAX 1..15");
    end

    typedef enum logic {IDLE, RD_BUSY} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       owner_d, owner_d_n;   // 1 = data port owns the read in flight
    logic       ret;                  // read-return cycle
    logic       free;                 // a new issue may happen this cycle
    logic       d_win, if_win;
    logic       fair_force;           // fetch must win a contest this cycle

    assign ret  = (state == RD_BUSY) && (cnt == LAT);
    assign free = (state == IDLE) || ret;

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] FMAX = 4'(FAIR_MAX);

    logic [3:0] fair_cnt;

    assign fair_force = if_req && (fair_cnt == FMAX);

    // Counts data grants that left a fetch waiting; saturates at FMAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fair_cnt <= '0;
        else if (if_gnt)
            fair_cnt <= '0;
        else if (d_gnt && if_req && (fair_cnt != FMAX))
            fair_cnt <= fair_cnt + 4'd1;
    end
`else
    assign fair_force = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            owner_d <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            owner_d <= owner_d_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the conditionals can leave a value unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        owner_d_n = owner_d;
        d_win     = 1'b0;
        if_win    = 1'b0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall_if  = 1'b0;
        stall_mem = 1'b0;

        if (d_req && !fair_force)
            d_win = 1'b1;
        else if (if_req)
            if_win = 1'b1;

        // Outputs are forced low for the whole time rst is high, even though
        // requests still arrive combinationally.
        if (!rst) begin
            if_gnt    = free && if_win;
            d_gnt     = free && d_win;
            if_rvalid = ret && !owner_d;
            d_rvalid  = ret && owner_d;
            if_rdata  = if_rvalid ? mem_rdata : '0;
            d_rdata   = d_rvalid  ? mem_rdata : '0;

            mem_en = if_gnt || d_gnt;
            if (d_gnt) begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else if (if_gnt) begin
                mem_addr  = if_addr;
            end

            stall_if  = if_req || ((state == RD_BUSY) && !owner_d && !ret);
            stall_mem = d_req  || ((state == RD_BUSY) &&  owner_d && !ret);
        end

        if (state == RD_BUSY) begin
            if (ret)
                state_n = IDLE;
            else
                cnt_n = cnt + 3'd1;
        end

        // An issue in the return cycle overrides the return-to-IDLE above.
        // Stores never leave IDLE: the memory is free again next cycle.
        if (d_gnt && !d_we) begin
            state_n   = RD_BUSY;
            cnt_n     = 3'd1;
            owner_d_n = 1'b1;
        end else if (if_gnt) begin
            state_n   = RD_BUSY;
            cnt_n     = 3'd1;
            owner_d_n = 1'b0;
        end
    end

endmodule
